// File: rtl/fp_pipe_sched.sv
// -----------------------------------------------------------------------------
// fp_pipe_sched
// Issue scheduler / sequencer for the 5-stage multi-precision FP multiply-add
// pipe. Grants one of two requesters (half / single precision), drives the
// shared calculate_mode select, tracks valid/tag/mode through every stage,
// stalls the whole pipe on output backpressure, and drains the pipe before
// any precision switch so in-flight entries never mix modes.
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   req_h_valid/tag/ready          half-precision requester handshake
//   req_s_valid/tag/ready          single-precision requester handshake
//   calculate_mode                 datapath precision select (1 = half)
//   issue_valid                    operands captured into stage 1 this cycle
//   stage_en                       common load enable for all stage registers
//   out_valid/out_ready            result handshake at the last stage
//   out_tag, out_mode              tag / mode of the result at the last stage
//   occupancy                      number of valid stages (0..STAGES)
//   busy                           pipe not empty or mid mode change
//
// FSM states
//   state     | meaning
//   ST_RUN    | issuing requests of the current mode
//   ST_DRAIN  | no issue; wait for the pipe to empty
//   ST_SWITCH | one cycle: toggle calculate_mode, clear burst counter
// -----------------------------------------------------------------------------
module fp_pipe_sched #(
    parameter int STAGES    = 5,
    parameter int TAG_W     = 4,
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_h_valid,
    input  logic [TAG_W-1:0] req_h_tag,
    output logic             req_h_ready,
    input  logic             req_s_valid,
    input  logic [TAG_W-1:0] req_s_tag,
    output logic             req_s_ready,
    output logic             calculate_mode,
    output logic             issue_valid,
    output logic             stage_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_mode,
    output logic [2:0]       occupancy,
    output logic             busy
);

    localparam logic MODE_HALF = 1'b1;
    localparam int   BW        = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              cmode_q, cmode_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [2:0]        occ_q, occ_d;

    // index 0 is stage 1, index STAGES-1 is the last stage
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] mode_q, mode_d;
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];

    logic              cur_valid;
    logic              other_valid;
    logic [TAG_W-1:0]  cur_tag;
    logic              burst_max;
    logic              grant;
    logic              xfer;

    // The favoured side after a switch is simply the new calculate_mode,
    // so the mode register doubles as the round-robin pointer.
    assign cur_valid   = (cmode_q == MODE_HALF) ? req_h_valid : req_s_valid;
    assign other_valid = (cmode_q == MODE_HALF) ? req_s_valid : req_h_valid;
    assign cur_tag     = (cmode_q == MODE_HALF) ? req_h_tag   : req_s_tag;
    assign burst_max   = (burst_q == BW'(MAX_BURST));

    assign stage_en = ~v_q[STAGES-1] | out_ready;
    assign xfer     = v_q[STAGES-1] & out_ready;

    // A waiting other-mode requester blocks further grants once the burst
    // limit is reached; that same cycle the FSM heads for DRAIN.
    assign grant = (state_q == ST_RUN) && stage_en && cur_valid &&
                   !(other_valid && burst_max);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (other_valid && (!cur_valid || burst_max)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // the switch is committed even if the other request drops
                if (occ_q == 3'd0) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        req_h_ready = 1'b0;
        req_s_ready = 1'b0;
        issue_valid = 1'b0;
        if (grant) begin
            issue_valid = 1'b1;
            if (cmode_q == MODE_HALF) begin
                req_h_ready = 1'b1;
            end else begin
                req_s_ready = 1'b1;
            end
        end
    end

    // ------------------------------------------------- mode / burst / count
    always_comb begin
        cmode_d = cmode_q;
        burst_d = burst_q;
        if (state_q == ST_SWITCH) begin
            cmode_d = ~cmode_q;
            burst_d = '0;
        end else if (!other_valid) begin
            burst_d = '0;
        end else if (grant) begin
            burst_d = burst_q + BW'(1);
        end
        occ_d = occ_q + {2'b00, grant} - {2'b00, xfer};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmode_q <= 1'b0;
            burst_q <= '0;
            occ_q   <= 3'd0;
        end else begin
            cmode_q <= cmode_d;
            burst_q <= burst_d;
            occ_q   <= occ_d;
        end
    end

    // ------------------------------------------------------- stage tracking
    always_comb begin
        v_d    = v_q;
        mode_d = mode_q;
        for (int i = 0; i < STAGES; i++) begin
            tag_d[i] = tag_q[i];
        end
        if (stage_en) begin
            // bubbles shift along with everything else; nothing collapses
            v_d    = {v_q[STAGES-2:0], grant};
            mode_d = {mode_q[STAGES-2:0], cmode_q};
            tag_d[0] = grant ? cur_tag : '0;
            for (int i = 1; i < STAGES; i++) begin
                tag_d[i] = tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            mode_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            v_q    <= v_d;
            mode_q <= mode_d;
            for (int i = 0; i < STAGES; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign calculate_mode = cmode_q;
    assign out_valid      = v_q[STAGES-1];
    assign out_tag        = tag_q[STAGES-1];
    assign out_mode       = mode_q[STAGES-1];
    assign occupancy      = occ_q;
    assign busy           = (occ_q != 3'd0) || (state_q != ST_RUN);

endmodule

// File: tb/tb_fp_pipe_sched.sv
`timescale 1ns/1ps
// Testbench for fp_pipe_sched: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_fp_pipe_sched;

    localparam int STAGES    = 5;
    localparam int TAG_W     = 4;
    localparam int MAX_BURST = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_h_valid, req_s_valid;
    logic [TAG_W-1:0] req_h_tag, req_s_tag;
    logic             req_h_ready, req_s_ready;
    logic             calculate_mode, issue_valid, stage_en;
    logic             out_valid, out_ready, out_mode, busy;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       occupancy;

    fp_pipe_sched #(.STAGES(STAGES), .TAG_W(TAG_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_h_valid(req_h_valid), .req_h_tag(req_h_tag), .req_h_ready(req_h_ready),
        .req_s_valid(req_s_valid), .req_s_tag(req_s_tag), .req_s_ready(req_s_ready),
        .calculate_mode(calculate_mode), .issue_valid(issue_valid), .stage_en(stage_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_mode(out_mode), .occupancy(occupancy), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------ model
    // In-flight work is a FIFO of entries, each knowing how many stages it
    // has advanced; an entry is presentable once it has reached STAGES.
    typedef struct {
        int tag;
        int mode;
        int pos;
    } ent_t;

    ent_t mq[$];
    int   m_mode  = 0;   // 1 = half
    int   m_phase = 0;   // 0 run, 1 drain, 2 switch
    int   m_burst = 0;

    bit   d_valid = 0;
    bit   d_xfer, d_en, d_issue;
    int   d_tag, d_phase_n, d_mode_n, d_burst_n;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_mode = 0; m_phase = 0; m_burst = 0;
            d_valid = 0;
            check("rst_out_valid", out_valid, 0);
            check("rst_occupancy", occupancy, 0);
            check("rst_mode", calculate_mode, 0);
            check("rst_h_ready", req_h_ready, 0);
            check("rst_s_ready", req_s_ready, 0);
            check("rst_issue", issue_valid, 0);
            check("rst_busy", busy, 0);
        end else begin
            bit full, en, cur_v, oth_v, gnt;
            full  = (mq.size() != 0) && (mq[0].pos == STAGES);
            en    = !full || out_ready;
            cur_v = m_mode ? req_h_valid : req_s_valid;
            oth_v = m_mode ? req_s_valid : req_h_valid;
            gnt   = (m_phase == 0) && en && cur_v && !(oth_v && m_burst == MAX_BURST);

            check("m_out_valid", out_valid, full);
            if (full) begin
                check("m_out_tag", out_tag, mq[0].tag);
                check("m_out_mode", out_mode, mq[0].mode);
                check("mode_inv", out_mode, calculate_mode);
            end
            check("m_stage_en", stage_en, en);
            check("m_h_ready", req_h_ready, gnt && m_mode == 1);
            check("m_s_ready", req_s_ready, gnt && m_mode == 0);
            check("m_issue", issue_valid, gnt);
            check("m_occupancy", occupancy, mq.size());
            check("m_mode", calculate_mode, m_mode);
            check("m_busy", busy, (mq.size() != 0) || (m_phase != 0));

            d_xfer  = full && out_ready;
            d_en    = en;
            d_issue = gnt;
            d_tag   = m_mode ? int'(req_h_tag) : int'(req_s_tag);
            d_mode_n  = (m_phase == 2) ? 1 - m_mode : m_mode;
            if (m_phase == 2 || !oth_v) d_burst_n = 0;
            else if (gnt)               d_burst_n = m_burst + 1;
            else                        d_burst_n = m_burst;
            case (m_phase)
                0:       d_phase_n = (oth_v && (!cur_v || m_burst == MAX_BURST)) ? 1 : 0;
                1:       d_phase_n = (mq.size() == 0) ? 2 : 1;
                default: d_phase_n = 0;
            endcase
            d_valid = 1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && d_valid) begin
            ent_t e;
            if (d_xfer) void'(mq.pop_front());
            if (d_en) foreach (mq[i]) mq[i].pos = mq[i].pos + 1;
            if (d_issue) begin
                e.tag = d_tag; e.mode = m_mode; e.pos = 1;
                mq.push_back(e);
            end
            m_phase = d_phase_n;
            m_mode  = d_mode_n;
            m_burst = d_burst_n;
        end
    end

    // ------------------------------------------------------ requesters
    logic [TAG_W-1:0] h_q[$];
    logic [TAG_W-1:0] s_q[$];

    task automatic drive_req();
        req_h_valid = (h_q.size() != 0);
        req_h_tag   = (h_q.size() != 0) ? h_q[0] : '0;
        req_s_valid = (s_q.size() != 0);
        req_s_tag   = (s_q.size() != 0) ? s_q[0] : '0;
    endtask

    // Advance one cycle; returns 2 time units after the rising edge with
    // requester inputs updated for any handshake completed at that edge.
    task automatic tick();
        logic h_acc, s_acc;
        @(negedge clk);
        h_acc = req_h_valid & req_h_ready;
        s_acc = req_s_valid & req_s_ready;
        @(posedge clk);
        #1;
        if (h_acc) void'(h_q.pop_front());
        if (s_acc) void'(s_q.pop_front());
        drive_req();
        #1;
    endtask

    task automatic wait_idle(string name);
        int n;
        n = 0;
        while ((h_q.size() != 0 || s_q.size() != 0 || busy) && n < 400) begin
            tick(); n++;
        end
        check(name, (n < 400), 1);
    endtask

    // ------------------------------------------------------ stimulus
    initial begin
        int n, n_h, n_s, last_h, stale;
        out_ready = 1'b1;
        drive_req();
        @(posedge clk); #2;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // single half request from reset (mode single): drain, switch, grant
        h_q.push_back(4'd3); drive_req(); #1;
        n = 0;
        while (!req_h_ready && n < 20) begin tick(); n++; end
        check("t1_grant_wait", n, 3);
        check("t1_mode_half", calculate_mode, 1);
        n = 0;
        do begin tick(); n++; end while (!out_valid && n < 20);
        check("t1_latency", n, 5);
        check("t1_tag", out_tag, 3);
        check("t1_mode", out_mode, 1);
        tick();
        check("t1_occ_zero", occupancy, 0);

        // five back-to-back halves into a stalled output
        out_ready = 1'b0;
        for (int i = 5; i <= 9; i++) h_q.push_back(TAG_W'(i));
        drive_req(); #1;
        n = 0;
        while (occupancy != 3'd5 && n < 20) begin tick(); n++; end
        check("t2_fill_cycles", n, 5);
        check("t2_stage_en", stage_en, 0);
        check("t2_out_tag", out_tag, 5);
        h_q.push_back(4'd10); drive_req(); #1;
        check("t2_held_off", req_h_ready, 0);
        tick(); tick();
        check("t2_stall_tag", out_tag, 5);
        check("t2_stall_occ", occupancy, 5);
        out_ready = 1'b1; #1;
        check("t5_issue_at_full", req_h_ready, 1);
        for (int k = 0; k < 6; k++) begin
            check("t2_drain_valid", out_valid, 1);
            check("t2_drain_tag", out_tag, 5 + k);
            if (k == 1) check("t5_occ_kept", occupancy, 5);
            tick();
        end
        check("t2_empty", out_valid, 0);
        check("t2_occ_zero", occupancy, 0);

        // both sides saturated: burst limit forces alternation
        for (int i = 0; i < 10; i++) begin
            h_q.push_back(TAG_W'(i));
            s_q.push_back(TAG_W'(15 - i));
        end
        drive_req(); #1;
        n = 0; n_h = 0; last_h = 0;
        while (!req_s_ready && n < 100) begin
            if (req_h_ready) begin n_h++; last_h = n; end
            tick(); n++;
        end
        check("t4_half_burst", n_h, 8);
        check("t4_switch_gap", n - last_h, 8);
        n_s = 0;
        while (!req_h_ready && n < 200) begin
            if (req_s_ready) n_s++;
            tick(); n++;
        end
        check("t4_single_burst", n_s, 8);
        wait_idle("t4_idle");

        // reset with work in flight in half mode
        h_q.push_back(4'd1); h_q.push_back(4'd2); h_q.push_back(4'd4);
        drive_req(); #1;
        n = 0;
        while (occupancy != 3'd3 && n < 40) begin tick(); n++; end
        check("t6_inflight", occupancy, 3);
        rst_n = 1'b0;
        h_q.delete(); drive_req(); #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_occ", occupancy, 0);
        check("t6_mode", calculate_mode, 0);
        tick(); tick();
        rst_n = 1'b1;
        stale = 0;
        repeat (12) begin tick(); if (out_valid) stale++; end
        check("t6_no_stale", stale, 0);

        // from reset: pending single goes first, halves only after drain
        s_q.push_back(4'd7);
        for (int i = 1; i <= 4; i++) h_q.push_back(TAG_W'(i));
        drive_req(); #1;
        check("t3_single_first", req_s_ready, 1);
        n = 0;
        while (!req_h_ready && n < 30) begin tick(); n++; end
        check("t3_half_wait", n, 8);
        check("t3_drained", occupancy, 0);
        wait_idle("t3_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
